// File: rtl/scs8hd_pwr_seq_ctrl.sv
// scs8hd_pwr_seq_ctrl: sleep/wake sequencer driving the island's header switch, isolation clamps and retention cells.
module scs8hd_pwr_seq_ctrl #(
  parameter int ISO_SETUP   = 2,
  parameter int PWR_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic CLK,
  input  logic RESETB,
  input  logic SLEEP_REQ,
  input  logic PWR_GOOD,
  output logic SLEEP_ACK,
  output logic PSW_EN,
  output logic ISO,
  output logic SAVE,
  output logic RESTORE,
  output logic BUSY,
  output logic ERR
);
  localparam logic [2:0] S_ON = 3'd0, S_ISO_ON = 3'd1, S_SAVE = 3'd2, S_PWR_DN = 3'd3,
                         S_OFF = 3'd4, S_PWR_UP = 3'd5, S_RST = 3'd6, S_ISO_OFF = 3'd7;
  localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] PWR_LD = CNT_W'(PWR_TIMEOUT - 1);
  logic [2:0] state, nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0] pg_sync;
  logic pg_s, cnt_z, tmo, up_fail, up_fail_n;
  assign pg_s  = pg_sync[1];
  assign cnt_z = cnt == '0;
  always_comb begin
    nxt       = state;
    cnt_n     = cnt;
    tmo       = 1'b0;
    up_fail_n = up_fail;
    case (state)
      S_ON:      if (SLEEP_REQ) begin nxt = S_ISO_ON; cnt_n = ISO_LD; end
      S_ISO_ON:  if (cnt_z) nxt = S_SAVE; else cnt_n = cnt - 1'b1;
      S_SAVE:    begin nxt = S_PWR_DN; cnt_n = PWR_LD; end
      S_PWR_DN:  if (!pg_s) nxt = S_OFF;
                 else if (cnt_z) begin nxt = S_OFF; tmo = 1'b1; end
                 else cnt_n = cnt - 1'b1;
      // A failed wake blocks retries until the requester re-asserts SLEEP_REQ.
      S_OFF:     if (SLEEP_REQ) up_fail_n = 1'b0;
                 else if (!up_fail) begin nxt = S_PWR_UP; cnt_n = PWR_LD; end
      S_PWR_UP:  if (pg_s) nxt = S_RST;
                 else if (cnt_z) begin nxt = S_OFF; tmo = 1'b1; up_fail_n = 1'b1; end
                 else cnt_n = cnt - 1'b1;
      S_RST:     begin nxt = S_ISO_OFF; cnt_n = ISO_LD; end
      S_ISO_OFF: if (cnt_z) nxt = S_ON; else cnt_n = cnt - 1'b1;
    endcase
  end
  // Outputs are decoded from the next state so they change on the entering edge.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state     <= S_ON;
      cnt       <= '0;
      pg_sync   <= 2'b11;
      up_fail   <= 1'b0;
      PSW_EN    <= 1'b1;
      ISO       <= 1'b0;
      SAVE      <= 1'b0;
      RESTORE   <= 1'b0;
      SLEEP_ACK <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_n;
      pg_sync   <= {pg_sync[0], PWR_GOOD};
      up_fail   <= up_fail_n;
      PSW_EN    <= !(nxt == S_PWR_DN || nxt == S_OFF);
      ISO       <= nxt != S_ON;
      SAVE      <= nxt == S_SAVE;
      RESTORE   <= nxt == S_RST;
      SLEEP_ACK <= nxt[2];
      BUSY      <= !(nxt == S_ON || nxt == S_OFF);
      ERR       <= nxt == S_ON ? 1'b0 : ERR | tmo;
    end
  end
endmodule
